// File: rtl/iter_rotator_right.sv
// Multi-cycle rotator: rotates an accepted word by in_amt positions, one bit per clock, with valid/ready on both sides.
// Optional feature macro DIR_SEL_EN adds in_dir (0 = rotate right, 1 = rotate left), captured at accept.
module iter_rotator_right #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
`ifdef DIR_SEL_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rot_r, rot_l;
`ifdef DIR_SEL_EN
    logic             dir_q, dir_d;
`endif

    // One-step rotations of the working register; the end bit wraps around.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        assign rot_r[gi] = data_q[(gi + 1) % WIDTH];
        assign rot_l[gi] = data_q[(gi + WIDTH - 1) % WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
`ifdef DIR_SEL_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef DIR_SEL_EN
            dir_q   <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef DIR_SEL_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    count_d = in_amt;
`ifdef DIR_SEL_EN
                    dir_d   = in_dir;
`endif
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
`ifdef DIR_SEL_EN
                data_d  = dir_q ? rot_l : rot_r;
`else
                data_d  = rot_r;
`endif
                count_d = count_q - AMT_W'(1);
                // SHIFT is only entered with count >= 1, so this never underflows.
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_iter_rotator_right.sv
// Self-checking bench for iter_rotator_right: directed cases, async reset mid-shift, then random traffic vs a rotate model.
module tb_iter_rotator_right;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_rotator_right #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
`ifdef DIR_SEL_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rotating left by a equals rotating right by (8 - a) mod 8.
    function automatic logic [7:0] model(input logic [7:0] d, input int a, input bit left);
        int v;
        int s;
        v = int'(d);
        s = left ? ((8 - a) % 8) : (a % 8);
        return 8'(((v >> s) | (v << (8 - s))) & 255);
    endfunction

    task automatic run_txn(input logic [7:0] d, input logic [2:0] a, input bit dir, input int hold);
        logic [7:0] exp;
        int         lat;
        bit         seen;
        bit         left;
`ifdef DIR_SEL_EN
        left = dir;
`else
        left = 1'b0;
`endif
        exp = model(d, int'(a), left);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        @(posedge clk);
        #1;
        // Keep offering garbage while busy: it must be ignored.
        in_data = 8'($urandom);
        in_amt  = 3'($urandom);
        in_dir  = 1'($urandom);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        in_valid = 1'b0;
        if (!seen) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("latency", lat, int'(a) + 1);
        check("out_data", out_data, exp);
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_busy", busy, 0);
        check("post_hs_data", out_data, exp);
        $display("txn data=%02h amt=%0d dir=%0d latency=%0d out=%02h exp=%02h", d, a, left, lat, out_data, exp);
    endtask

    initial begin
        bit spurious;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 8'h00);

        run_txn(8'b1000_0000, 3'd3, 1'b0, 0);
        run_txn(8'b1011_0001, 3'd0, 1'b0, 0);
        run_txn(8'b0000_0001, 3'd1, 1'b0, 0);
        run_txn(8'b1011_0001, 3'd7, 1'b0, 5);
        check("amt7_direct", out_data, 8'b0110_0011);
`ifdef DIR_SEL_EN
        run_txn(8'b1000_0001, 3'd2, 1'b1, 0);
        check("dir_left_direct", out_data, 8'b0000_0110);
`endif
        run_txn(8'b1000_0001, 3'd2, 1'b0, 0);
        check("dir_right_direct", out_data, 8'b0110_0000);

        // Async reset in the middle of a shift.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_amt   = 3'd5;
        in_dir   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) spurious = 1'b1;
        end
        check("no_valid_after_rst", spurious, 0);
        $display("reset mid-shift: spurious_valid=%0d", spurious);
        run_txn(8'hF0, 3'd5, 1'b0, 1);

        for (int t = 0; t < 30; t++) begin
            run_txn(8'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
